// File: rtl/hazard_pkg.sv
// Shared types for the hazard response unit: front-end FSM state encoding and the default bubble encoding.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

    localparam logic [15:0] NOP_INST_DEFAULT = 16'h0000;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous clear; at_max flags that the value loaded this edge equals MAX.
// One-cycle update, no backpressure: increments beyond MAX are dropped.
module hazard_sat_counter #(
    parameter int MAX = 15,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (inc && (count != W'(MAX))) begin
            count_nxt = count + 1'b1;
        end
    end

    // Looks at the next value so the owner can react on the same edge that reaches MAX.
    assign at_max = (count_nxt == W'(MAX));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/pipeline_hazard_response_unit.sv
// Front-end hazard response: owns IF/ID, PC enable/select, ID/EX bubble, branch flush and stall watchdog.
// Control outputs are combinational, IF/ID updates one edge later; optional perf counters via HAZARD_PERF_CNT_EN.
module pipeline_hazard_response_unit
    import hazard_pkg::*;
#(
    parameter int                WIDTH        = 16,
    parameter int                FLUSH_CYCLES = 1,
    parameter int                MAX_STALL    = 15,
    parameter logic [WIDTH-1:0]  NOP_INST     = WIDTH'(NOP_INST_DEFAULT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] if_inst,
    input  logic [WIDTH-1:0] if_pc,
    output logic             pc_write,
    output logic             pc_sel_target,
    output logic             ex_bubble,
    output logic [WIDTH-1:0] id_inst,
    output logic [WIDTH-1:0] id_pc,
    output logic             id_valid,
    output logic             stall_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]      perf_stall_cnt,
    output logic [15:0]      perf_flush_cnt
`endif
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int SW = $clog2(MAX_STALL + 1);

    hz_state_t     state, state_nxt;
    logic [FW-1:0] flush_cnt, flush_cnt_nxt;
    logic [SW-1:0] stall_cnt;
    logic          stall_acc;
    logic          stall_hit_max;

    // stall is active-low; branches and flush slots always override it.
    assign stall_acc = !stall && (state != FLUSH) && !branch_taken && !stall_timeout;

    // The target PC itself is muxed outside; this block only drives the select.
    logic unused_target;
    assign unused_target = ^branch_target;

    hazard_sat_counter #(
        .MAX (MAX_STALL),
        .W   (SW)
    ) u_stall_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (!stall_acc),
        .inc    (stall_acc),
        .count  (stall_cnt),
        .at_max (stall_hit_max)
    );

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        pc_write      = 1'b1;
        pc_sel_target = 1'b0;
        ex_bubble     = 1'b0;
        if (branch_taken) begin
            pc_sel_target = 1'b1;
            state_nxt     = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
            flush_cnt_nxt = FW'(FLUSH_CYCLES - 1);
        end else if (stall_acc) begin
            pc_write  = 1'b0;
            ex_bubble = 1'b1;
            state_nxt = STALL;
        end else if (state == FLUSH) begin
            flush_cnt_nxt = flush_cnt - 1'b1;
            if (flush_cnt == FW'(1)) begin
                state_nxt = RUN;
            end
        end else begin
            state_nxt = RUN;
        end
        if (reset) begin
            pc_write      = 1'b0;
            pc_sel_target = 1'b0;
            ex_bubble     = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            flush_cnt     <= '0;
            id_inst       <= NOP_INST;
            id_pc         <= '0;
            id_valid      <= 1'b0;
            stall_timeout <= 1'b0;
        end else begin
            state         <= state_nxt;
            flush_cnt     <= flush_cnt_nxt;
            stall_timeout <= stall_timeout | stall_hit_max;
            if (branch_taken || (state == FLUSH)) begin
                id_inst  <= NOP_INST;
                id_valid <= 1'b0;
            end else if (!stall_acc) begin
                id_inst  <= if_inst;
                id_pc    <= if_pc;
                id_valid <= 1'b1;
            end
        end
    end

    logic unused_cnt;
    assign unused_cnt = ^stall_cnt;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + {15'd0, stall_acc};
            perf_flush_cnt <= perf_flush_cnt + {15'd0, branch_taken};
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_response_unit.sv
// Bench for pipeline_hazard_response_unit with FLUSH_CYCLES=2, MAX_STALL=15 against a cycle-level reference model.
module tb_pipeline_hazard_response_unit;

    localparam int          FC  = 2;
    localparam int          MS  = 15;
    localparam logic [15:0] NOP = 16'h0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b1;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic [15:0] if_inst = '0;
    logic [15:0] if_pc = '0;
    logic        pc_write, pc_sel_target, ex_bubble, id_valid, stall_timeout;
    logic [15:0] id_inst, id_pc;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

    pipeline_hazard_response_unit #(
        .WIDTH        (16),
        .FLUSH_CYCLES (FC),
        .MAX_STALL    (MS),
        .NOP_INST     (NOP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .pc_write      (pc_write),
        .pc_sel_target (pc_sel_target),
        .ex_bubble     (ex_bubble),
        .id_inst       (id_inst),
        .id_pc         (id_pc),
        .id_valid      (id_valid),
        .stall_timeout (stall_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: what IF/ID should hold and how many flush slots / stall cycles are outstanding.
    logic [15:0] m_inst, m_pc, m_pstall, m_pflush;
    logic        m_valid, m_to;
    int          flush_left, stall_run;
    logic        o_pw, o_sel, o_bub, e_pw, e_sel, e_bub;

    task automatic model_reset();
        m_inst = NOP; m_pc = '0; m_valid = 1'b0; m_to = 1'b0;
        flush_left = 0; stall_run = 0; m_pstall = '0; m_pflush = '0;
    endtask

    // Applies one cycle of inputs, samples the combinational outputs, and advances the model past the edge.
    task automatic drive(input logic s, input logic b, input logic [15:0] tgt,
                         input logic [15:0] inst, input logic [15:0] pc);
        logic acc;
        stall = s; branch_taken = b; branch_target = tgt; if_inst = inst; if_pc = pc;
        #1;
        o_pw = pc_write; o_sel = pc_sel_target; o_bub = ex_bubble;
        acc   = !s && (flush_left == 0) && !b && !m_to;
        e_pw  = b || !acc;
        e_sel = b;
        e_bub = acc;
        @(posedge clock);
        if (b) begin
            m_inst = NOP; m_valid = 1'b0; flush_left = FC - 1; stall_run = 0;
            m_pflush = m_pflush + 16'd1;
        end else if (acc) begin
            stall_run = (stall_run < MS) ? stall_run + 1 : MS;
            if (stall_run == MS) m_to = 1'b1;
            m_pstall = m_pstall + 16'd1;
        end else if (flush_left > 0) begin
            m_inst = NOP; m_valid = 1'b0; flush_left--; stall_run = 0;
        end else begin
            m_inst = inst; m_pc = pc; m_valid = 1'b1; stall_run = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (pc_write !== 1'b0) begin n_bad++; $display("FAIL reset_pc_write got=%b exp=0", pc_write); end
        n_checks++; if (pc_sel_target !== 1'b0) begin n_bad++; $display("FAIL reset_pc_sel got=%b exp=0", pc_sel_target); end
        n_checks++; if (ex_bubble !== 1'b1) begin n_bad++; $display("FAIL reset_bubble got=%b exp=1", ex_bubble); end
        n_checks++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
        n_checks++; if (id_inst !== NOP) begin n_bad++; $display("FAIL reset_id_inst got=%h exp=%h", id_inst, NOP); end
        n_checks++; if (id_pc !== 16'h0) begin n_bad++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
        n_checks++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got=%b exp=0", stall_timeout); end
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++; if (pc_write !== 1'b1) begin n_bad++; $display("FAIL released_pc_write got=%b exp=1", pc_write); end
    endtask

    task automatic test_run();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'h0, 16'(16'h1111 * (i + 1)), 16'(16'h0010 + 2 * i));
            n_checks++; if (o_pw !== 1'b1) begin n_bad++; $display("FAIL run_pc_write cyc=%0d got=%b exp=1", i, o_pw); end
            n_checks++; if (id_inst !== 16'(16'h1111 * (i + 1))) begin n_bad++; $display("FAIL run_id_inst cyc=%0d got=%h exp=%h", i, id_inst, 16'(16'h1111 * (i + 1))); end
            n_checks++; if (id_pc !== m_pc) begin n_bad++; $display("FAIL run_id_pc cyc=%0d got=%h exp=%h", i, id_pc, m_pc); end
            n_checks++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL run_id_valid cyc=%0d got=%b exp=1", i, id_valid); end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 16'h0, 16'h4444, 16'h0016);
            n_checks++; if (o_pw !== 1'b0) begin n_bad++; $display("FAIL stall_pc_write cyc=%0d got=%b exp=0", i, o_pw); end
            n_checks++; if (o_bub !== 1'b1) begin n_bad++; $display("FAIL stall_bubble cyc=%0d got=%b exp=1", i, o_bub); end
            n_checks++; if (id_inst !== 16'h3333) begin n_bad++; $display("FAIL stall_hold cyc=%0d got=%h exp=3333", i, id_inst); end
        end
        drive(1'b1, 1'b0, 16'h0, 16'h4444, 16'h0016);
        n_checks++; if (o_pw !== 1'b1) begin n_bad++; $display("FAIL release_pc_write got=%b exp=1", o_pw); end
        n_checks++; if (id_inst !== 16'h4444) begin n_bad++; $display("FAIL release_id_inst got=%h exp=4444", id_inst); end
    endtask

    task automatic test_branch();
        drive(1'b1, 1'b1, 16'h0040, 16'h5555, 16'h0018);
        n_checks++; if (o_sel !== 1'b1) begin n_bad++; $display("FAIL br_pc_sel got=%b exp=1", o_sel); end
        n_checks++; if (o_pw !== 1'b1) begin n_bad++; $display("FAIL br_pc_write got=%b exp=1", o_pw); end
        n_checks++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL br_squash1 got=%b exp=0", id_valid); end
        // stall during the flush slot must be ignored
        drive(1'b0, 1'b0, 16'h0, 16'h6666, 16'h0040);
        n_checks++; if (o_pw !== 1'b1 || o_bub !== 1'b0 || o_sel !== 1'b0) begin n_bad++; $display("FAIL flush_ctrl got=%b%b%b exp=100", o_pw, o_bub, o_sel); end
        n_checks++; if (id_valid !== 1'b0 || id_inst !== NOP) begin n_bad++; $display("FAIL br_squash2 got=%b/%h exp=0/%h", id_valid, id_inst, NOP); end
        drive(1'b1, 1'b0, 16'h0, 16'h7777, 16'h0042);
        n_checks++; if (id_valid !== 1'b1 || id_inst !== 16'h7777) begin n_bad++; $display("FAIL br_resume got=%b/%h exp=1/7777", id_valid, id_inst); end
    endtask

    task automatic test_branch_stall();
        drive(1'b0, 1'b1, 16'h0080, 16'h8888, 16'h0044);
        n_checks++; if (o_pw !== 1'b1 || o_bub !== 1'b0 || o_sel !== 1'b1) begin n_bad++; $display("FAIL brst_ctrl got=%b%b%b exp=101", o_pw, o_bub, o_sel); end
        n_checks++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL brst_squash got=%b exp=0", id_valid); end
        drive(1'b1, 1'b0, 16'h0, 16'h8888, 16'h0080);
        n_checks++; if (id_valid !== m_valid) begin n_bad++; $display("FAIL brst_flush got=%b exp=%b", id_valid, m_valid); end
        drive(1'b1, 1'b0, 16'h0, 16'h9999, 16'h0082);
        n_checks++; if (id_inst !== 16'h9999 || id_pc !== 16'h0082) begin n_bad++; $display("FAIL brst_resume got=%h@%h exp=9999@0082", id_inst, id_pc); end
    endtask

    task automatic test_watchdog();
        drive(1'b1, 1'b0, 16'h0, 16'h1234, 16'h0050);
        for (int i = 1; i <= 20; i++) begin
            drive(1'b0, 1'b0, 16'h0, 16'hAAAA, 16'h0052);
            n_checks++; if (o_pw !== e_pw || o_pw !== (i > MS)) begin n_bad++; $display("FAIL wd_pc_write cyc=%0d got=%b exp=%b", i, o_pw, e_pw); end
            n_checks++; if (stall_timeout !== m_to || stall_timeout !== (i >= MS)) begin n_bad++; $display("FAIL wd_timeout cyc=%0d got=%b exp=%b", i, stall_timeout, m_to); end
        end
        drive(1'b1, 1'b0, 16'h0, 16'hBBBB, 16'h0054);
        n_checks++; if (stall_timeout !== 1'b1) begin n_bad++; $display("FAIL wd_sticky got=%b exp=1", stall_timeout); end
        reset = 1'b1;
        #2;
        n_checks++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL wd_reset_clear got=%b exp=0", stall_timeout); end
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic s, b;
        for (int i = 0; i < 300; i++) begin
            s = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 9) == 0);
            drive(s, b, 16'($urandom), 16'($urandom), 16'($urandom));
            n_checks++; if ({o_pw, o_sel, o_bub} !== {e_pw, e_sel, e_bub}) begin n_bad++; $display("FAIL rnd_ctrl cyc=%0d got=%b%b%b exp=%b%b%b", i, o_pw, o_sel, o_bub, e_pw, e_sel, e_bub); end
            n_checks++; if (id_valid !== m_valid || id_inst !== m_inst) begin n_bad++; $display("FAIL rnd_ifid cyc=%0d got=%b/%h exp=%b/%h", i, id_valid, id_inst, m_valid, m_inst); end
            if (m_valid) begin
                n_checks++; if (id_pc !== m_pc) begin n_bad++; $display("FAIL rnd_id_pc cyc=%0d got=%h exp=%h", i, id_pc, m_pc); end
            end
            n_checks++; if (stall_timeout !== m_to) begin n_bad++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", i, stall_timeout, m_to); end
`ifdef HAZARD_PERF_CNT_EN
            n_checks++; if (perf_stall_cnt !== m_pstall || perf_flush_cnt !== m_pflush) begin n_bad++; $display("FAIL rnd_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", i, perf_stall_cnt, perf_flush_cnt, m_pstall, m_pflush); end
`endif
        end
    endtask

    task automatic test_reset_mid_flush();
        drive(1'b1, 1'b0, 16'h0, 16'h0F0F, 16'h0100);
        drive(1'b1, 1'b1, 16'h0200, 16'hCCCC, 16'h0102);
        reset = 1'b1;
        #1;
        n_checks++; if (id_valid !== 1'b0 || id_inst !== NOP) begin n_bad++; $display("FAIL rmf_ifid got=%b/%h exp=0/%h", id_valid, id_inst, NOP); end
        n_checks++; if (pc_write !== 1'b0 || ex_bubble !== 1'b1) begin n_bad++; $display("FAIL rmf_ctrl got=%b%b exp=01", pc_write, ex_bubble); end
`ifdef HAZARD_PERF_CNT_EN
        n_checks++; if (perf_stall_cnt !== 16'd0 || perf_flush_cnt !== 16'd0) begin n_bad++; $display("FAIL rmf_perf got=%0d/%0d exp=0/0", perf_stall_cnt, perf_flush_cnt); end
`endif
        @(posedge clock);
        #2;
        reset = 1'b0;
        model_reset();
        // A leftover FLUSH state would squash this instruction instead of loading it.
        drive(1'b1, 1'b0, 16'h0, 16'hBEEF, 16'h0300);
        n_checks++; if (id_valid !== 1'b1 || id_inst !== 16'hBEEF) begin n_bad++; $display("FAIL rmf_run got=%b/%h exp=1/beef", id_valid, id_inst); end
        n_checks++; if (o_pw !== 1'b1 || o_bub !== 1'b0) begin n_bad++; $display("FAIL rmf_run_ctrl got=%b%b exp=10", o_pw, o_bub); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run();
        test_stall();
        test_branch();
        test_branch_stall();
        test_watchdog();
        test_random();
        test_reset_mid_flush();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit reached");
        $fatal(1);
    end

endmodule
